// File: rtl/rva_host_initiator.sv
// rva_host_initiator: host-side initiator for the RVA register/vector access protocol.
// Registers one host command at a time toward the PE. Queues PE read data in an in-order
// show-ahead FIFO and returns it to the host. Read credits prevent the FIFO from overflowing.
// Optional feature: define RVA_RESP_TIMEOUT_EN to add the outstanding-read watchdog that
// drives timeout_err; without it timeout_err is constant 0.
module rva_host_initiator #(
  parameter int RESP_DEPTH  = 4,
  parameter int CNT_W       = $clog2(RESP_DEPTH) + 1,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [168:0]     cmd_msg,
  input  logic             cmd_val,
  output logic             cmd_rdy,
  output logic [168:0]     rva_in_msg,
  output logic             rva_in_val,
  input  logic             rva_in_rdy,
  input  logic [127:0]     rva_out_msg,
  input  logic             rva_out_val,
  output logic             rva_out_rdy,
  output logic [127:0]     resp_msg,
  output logic             resp_val,
  input  logic             resp_rdy,
  output logic [CNT_W-1:0] rd_outstanding,
  output logic             busy,
  output logic             err_unexp,
  output logic             timeout_err
);

  localparam int AW = $clog2(RESP_DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [CNT_W:0]   DEPTH_C = (CNT_W+1)'(RESP_DEPTH);
  localparam logic [AW-1:0]    PTR_ONE = AW'(1);

  logic              run;
  logic [CNT_W-1:0]  fifo_count;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [127:0]      fifo_mem [RESP_DEPTH];
  logic [CNT_W:0]    used;
  logic              has_credit;
  logic              cmd_take;
  logic              rd_take;
  logic              rsp_take;
  logic              rsp_push;
  logic              rsp_drop;
  logic              resp_pop;

  // A read needs a credit: outstanding reads plus queued responses must leave a free FIFO slot.
  assign used       = {1'b0, rd_outstanding} + {1'b0, fifo_count};
  assign has_credit = (used < DEPTH_C);

  assign cmd_rdy  = run & (~rva_in_val | rva_in_rdy) & (cmd_msg[168] | has_credit);
  assign cmd_take = cmd_val & cmd_rdy;
  assign rd_take  = cmd_take & ~cmd_msg[168];

  assign rva_out_rdy = run;
  assign rsp_take    = rva_out_val & rva_out_rdy;
  assign rsp_push    = rsp_take & (rd_outstanding != '0);
  assign rsp_drop    = rsp_take & (rd_outstanding == '0);

  assign resp_val = (fifo_count != '0);
  assign resp_msg = fifo_mem[rd_ptr];
  assign resp_pop = resp_val & resp_rdy;

  assign busy = rva_in_val | (rd_outstanding != '0) | resp_val;

  // Run flag keeps every handshake output low while reset is held and rises one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) run <= 1'b0;
    else      run <= 1'b1;
  end

  // Single-entry command stage; message and valid hold while the PE stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rva_in_msg <= '0;
      rva_in_val <= 1'b0;
    end else if (cmd_take) begin
      rva_in_msg <= cmd_msg;
      rva_in_val <= 1'b1;
    end else if (rva_in_rdy) begin
      rva_in_val <= 1'b0;
    end
  end

  // Outstanding reads: credit taken at command accept, returned when the PE answers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_outstanding <= '0;
    end else begin
      case ({rd_take, rsp_push})
        2'b10:   rd_outstanding <= rd_outstanding + ONE_C;
        2'b01:   rd_outstanding <= rd_outstanding - ONE_C;
        default: rd_outstanding <= rd_outstanding;
      endcase
    end
  end

  // Sticky flag for a PE response that no read was waiting for.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          err_unexp <= 1'b0;
    else if (rsp_drop) err_unexp <= 1'b1;
  end

  // In-order show-ahead response FIFO; storage is cleared so resp_msg reads 0 out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RESP_DEPTH; i++) fifo_mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (rsp_push) begin
        fifo_mem[wr_ptr] <= rva_out_msg;
        wr_ptr           <= wr_ptr + PTR_ONE;
      end
      if (resp_pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({rsp_push, resp_pop})
        2'b10:   fifo_count <= fifo_count + ONE_C;
        2'b01:   fifo_count <= fifo_count - ONE_C;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

`ifdef RVA_RESP_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYC);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

  logic [WD_W-1:0] wd_cnt;

  // Watchdog counts cycles without a response while reads are pending; flag is sticky.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else if (rsp_take || (rd_outstanding == '0)) begin
      wd_cnt <= '0;
    end else if (wd_cnt != WD_MAX) begin
      wd_cnt <= wd_cnt + WD_ONE;
      if (wd_cnt == WD_LAST) timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_rva_host_initiator.sv
// tb_rva_host_initiator: directed bench for rva_host_initiator with a read-data scoreboard.
// Inputs change 2 time units after a rising edge and outputs are sampled 1 unit later.
module tb_rva_host_initiator;

  localparam int RESP_DEPTH = 4;
  localparam int CNT_W      = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [168:0]     cmd_msg;
  logic             cmd_val;
  logic             cmd_rdy;
  logic [168:0]     rva_in_msg;
  logic             rva_in_val;
  logic             rva_in_rdy;
  logic [127:0]     rva_out_msg;
  logic             rva_out_val;
  logic             rva_out_rdy;
  logic [127:0]     resp_msg;
  logic             resp_val;
  logic             resp_rdy;
  logic [CNT_W-1:0] rd_outstanding;
  logic             busy;
  logic             err_unexp;
  logic             timeout_err;

  int n_asserts = 0;
  int n_fail    = 0;

  logic [127:0] exp_q [$];
  logic [168:0] wr_cmd;
  logic [168:0] rd_cmd;

  rva_host_initiator #(
    .RESP_DEPTH (RESP_DEPTH),
    .CNT_W      (CNT_W),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_msg       (cmd_msg),
    .cmd_val       (cmd_val),
    .cmd_rdy       (cmd_rdy),
    .rva_in_msg    (rva_in_msg),
    .rva_in_val    (rva_in_val),
    .rva_in_rdy    (rva_in_rdy),
    .rva_out_msg   (rva_out_msg),
    .rva_out_val   (rva_out_val),
    .rva_out_rdy   (rva_out_rdy),
    .resp_msg      (resp_msg),
    .resp_val      (resp_val),
    .resp_rdy      (resp_rdy),
    .rd_outstanding(rd_outstanding),
    .busy          (busy),
    .err_unexp     (err_unexp),
    .timeout_err   (timeout_err)
  );

  // 10-unit clock period
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  function automatic logic [168:0] mk_cmd(input logic rw, input logic [23:0] addr,
                                          input logic [127:0] data, input logic [15:0] wstrb);
    return {rw, addr, data, wstrb};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_output(input string tag, input logic [168:0] obs, input logic [168:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_cmd_rdy"}, 169'(cmd_rdy), 169'(0));
    check_output({tag, "_rva_in_val"}, 169'(rva_in_val), 169'(0));
    check_output({tag, "_rva_in_msg"}, rva_in_msg, 169'(0));
    check_output({tag, "_rva_out_rdy"}, 169'(rva_out_rdy), 169'(0));
    check_output({tag, "_resp_val"}, 169'(resp_val), 169'(0));
    check_output({tag, "_resp_msg"}, 169'(resp_msg), 169'(0));
    check_output({tag, "_rd_outstanding"}, 169'(rd_outstanding), 169'(0));
    check_output({tag, "_busy"}, 169'(busy), 169'(0));
    check_output({tag, "_err_unexp"}, 169'(err_unexp), 169'(0));
    check_output({tag, "_timeout_err"}, 169'(timeout_err), 169'(0));
  endtask

  // Compare the FIFO head with the oldest scoreboard entry, then pop it for one edge
  task automatic pop_resp(input string tag);
    logic [127:0] exp_data;
    if (exp_q.size() == 0) begin
      n_asserts++;
      n_fail++;
      $error("[TB] FAIL %s_scoreboard: observed=empty expected=entry", tag);
    end else begin
      exp_data = exp_q.pop_front();
      check_output({tag, "_resp_val"}, 169'(resp_val), 169'(1));
      check_output({tag, "_resp_msg"}, 169'(resp_msg), 169'(exp_data));
    end
    resp_rdy = 1'b1;
    tick();
    resp_rdy = 1'b0;
  endtask

  // Drive one PE response for a single edge
  task automatic apply_stimulus(input logic [127:0] data);
    rva_out_msg = data;
    rva_out_val = 1'b1;
    tick();
    rva_out_val = 1'b0;
    rva_out_msg = '0;
  endtask

  initial begin
    rst         = 1'b0;
    cmd_msg     = '0;
    cmd_val     = 1'b0;
    rva_in_rdy  = 1'b0;
    rva_out_msg = '0;
    rva_out_val = 1'b0;
    resp_rdy    = 1'b0;

    // Reset state
    #3;
    check_reset_outputs("reset");
    tick();
    rst = 1'b1;
    tick();
    #1;
    check_output("post_reset_cmd_rdy", 169'(cmd_rdy), 169'(1));
    check_output("post_reset_rva_out_rdy", 169'(rva_out_rdy), 169'(1));

    // 1: write held while the PE stalls for three cycles
    $display("[TB] step 1: stalled write");
    wr_cmd  = mk_cmd(1'b1, 24'h000010, 128'h01, 16'hFFFF);
    cmd_msg = wr_cmd;
    cmd_val = 1'b1;
    #1;
    check_output("t1_cmd_rdy_accept", 169'(cmd_rdy), 169'(1));
    tick();
    cmd_val = 1'b0;
    cmd_msg = '0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_output("t1_rva_in_val", 169'(rva_in_val), 169'(1));
      check_output("t1_rva_in_msg", rva_in_msg, wr_cmd);
      check_output("t1_cmd_rdy_stall", 169'(cmd_rdy), 169'(0));
      check_output("t1_rd_outstanding", 169'(rd_outstanding), 169'(0));
      check_output("t1_resp_val", 169'(resp_val), 169'(0));
      tick();
    end
    rva_in_rdy = 1'b1;
    #1;
    check_output("t1_cmd_rdy_release", 169'(cmd_rdy), 169'(1));
    tick();
    #1;
    check_output("t1_retired_val", 169'(rva_in_val), 169'(0));
    check_output("t1_retired_busy", 169'(busy), 169'(0));

    // 2: single read answered five cycles later
    $display("[TB] step 2: single read");
    rd_cmd  = mk_cmd(1'b0, 24'h000020, 128'h0, 16'h0);
    cmd_msg = rd_cmd;
    cmd_val = 1'b1;
    exp_q.push_back(128'hDEADBEEF);
    #1;
    check_output("t2_cmd_rdy", 169'(cmd_rdy), 169'(1));
    tick();
    cmd_val = 1'b0;
    #1;
    check_output("t2_rd_outstanding_1", 169'(rd_outstanding), 169'(1));
    check_output("t2_rva_in_msg", rva_in_msg, rd_cmd);
    tick();
    #1;
    check_output("t2_pe_took", 169'(rva_in_val), 169'(0));
    repeat (3) tick();
    check_output("t2_resp_val_before", 169'(resp_val), 169'(0));
    apply_stimulus(128'hDEADBEEF);
    #1;
    check_output("t2_rd_outstanding_0", 169'(rd_outstanding), 169'(0));
    pop_resp("t2");
    #1;
    check_output("t2_resp_val_after", 169'(resp_val), 169'(0));
    check_output("t2_busy_after", 169'(busy), 169'(0));

    // 3: five reads against four credits with the host not draining
    $display("[TB] step 3: credit limit");
    cmd_val = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cmd_msg = mk_cmd(1'b0, 24'h000100 + 24'(i), 128'h0, 16'h0);
      exp_q.push_back(128'h1000 + 128'(i));
      #1;
      check_output("t3_cmd_rdy_credit", 169'(cmd_rdy), 169'(1));
      tick();
    end
    cmd_msg = mk_cmd(1'b0, 24'h000104, 128'h0, 16'h0);
    #1;
    check_output("t3_fifth_blocked", 169'(cmd_rdy), 169'(0));
    check_output("t3_rd_outstanding_4", 169'(rd_outstanding), 169'(4));
    for (int j = 0; j < 4; j++) begin
      apply_stimulus(128'h1000 + 128'(j));
      #1;
      check_output("t3_blocked_while_full", 169'(cmd_rdy), 169'(0));
    end
    check_output("t3_rd_outstanding_0", 169'(rd_outstanding), 169'(0));
    pop_resp("t3_first");
    #1;
    check_output("t3_fifth_unblocked", 169'(cmd_rdy), 169'(1));
    exp_q.push_back(128'h1004);
    tick();
    cmd_val = 1'b0;
    #1;
    check_output("t3_fifth_outstanding", 169'(rd_outstanding), 169'(1));
    tick();
    apply_stimulus(128'h1004);
    for (int k = 0; k < 4; k++) pop_resp("t3_drain");
    #1;
    check_output("t3_drained", 169'(resp_val), 169'(0));

    // 4: response with nothing outstanding
    $display("[TB] step 4: unexpected response");
    apply_stimulus(128'h55);
    #1;
    check_output("t4_err_unexp", 169'(err_unexp), 169'(1));
    check_output("t4_resp_val", 169'(resp_val), 169'(0));
    check_output("t4_busy", 169'(busy), 169'(0));

    // 5: silent PE and the watchdog
    $display("[TB] step 5: silent PE");
    cmd_msg = mk_cmd(1'b0, 24'h000030, 128'h0, 16'h0);
    cmd_val = 1'b1;
    exp_q.push_back(128'hABCD);
    tick();
    cmd_val = 1'b0;
    repeat (8) tick();
    #1;
    check_output("t5_timeout_early", 169'(timeout_err), 169'(0));
    repeat (12) tick();
    #1;
`ifdef RVA_RESP_TIMEOUT_EN
    check_output("t5_timeout_late", 169'(timeout_err), 169'(1));
`else
    check_output("t5_timeout_late", 169'(timeout_err), 169'(0));
`endif
    apply_stimulus(128'hABCD);
    pop_resp("t5");

    // 6: reset in the middle of a read burst
    $display("[TB] step 6: reset mid-burst");
    cmd_val = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cmd_msg = mk_cmd(1'b0, 24'h000200 + 24'(i), 128'h0, 16'h0);
      tick();
    end
    cmd_val = 1'b0;
    tick();
    apply_stimulus(128'h2000);
    #1;
    check_output("t6_resp_queued", 169'(resp_val), 169'(1));
    check_output("t6_outstanding_2", 169'(rd_outstanding), 169'(2));
    rst = 1'b0;
    #1;
    check_reset_outputs("t6_reset");
    exp_q.delete();
    tick();
    rst = 1'b1;
    tick();
    rva_out_msg = 128'h2001;
    rva_out_val = 1'b1;
    #1;
    check_output("t6_rva_out_rdy", 169'(rva_out_rdy), 169'(1));
    tick();
    rva_out_val = 1'b0;
    #1;
    check_output("t6_late_resp_err", 169'(err_unexp), 169'(1));
    check_output("t6_late_resp_dropped", 169'(resp_val), 169'(0));
    cmd_val = 1'b1;
    for (int i = 0; i < RESP_DEPTH; i++) begin
      cmd_msg = mk_cmd(1'b0, 24'h000300 + 24'(i), 128'h0, 16'h0);
      #1;
      check_output("t6_full_credit", 169'(cmd_rdy), 169'(1));
      tick();
    end
    #1;
    check_output("t6_credit_exhausted", 169'(cmd_rdy), 169'(0));
    check_output("t6_outstanding_full", 169'(rd_outstanding), 169'(RESP_DEPTH));
    cmd_val = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
